// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: one 32-bit load/store becomes two 16-bit
// accesses (low half, then high half) to an asynchronous SRAM, each stretched by WAIT_CYCLES.
module mem_access_ctrl #(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_out,
   output logic        sram_dq_oe,
   input  logic [15:0] sram_dq_in,
   output logic        sram_we_n,
   output logic        sram_oe_n
);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

   state_t      state;
   state_t      state_next;
   logic [2:0]  cnt;
   logic [2:0]  cnt_next;
   logic        start;
   logic        last;
   logic        in_phase;
   logic        is_wr;
   logic [16:0] word;
   logic [15:0] wdata_hi;
   logic        unused_addr;

   assign last        = (cnt == LAST_CNT);
   assign unused_addr = ^{address[31:19], address[1:0]};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of always-block ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      start      = 1'b0;
      ready      = 1'b0;
      in_phase   = 1'b0;
      case (state)
         IDLE: begin
            ready = ~(rd_en | wr_en);
            if (rd_en | wr_en) begin
               start      = 1'b1;
               cnt_next   = '0;
               state_next = LO;
            end
         end
         LO: begin
            in_phase = 1'b1;
            if (last) begin
               cnt_next   = '0;
               state_next = HI;
            end else begin
               cnt_next = cnt + 3'd1;
            end
         end
         HI: begin
            in_phase = 1'b1;
            if (last) begin
               cnt_next   = '0;
               state_next = DONE;
            end else begin
               cnt_next = cnt + 3'd1;
            end
         end
         DONE: begin
            // Request still held by the frozen pipeline belongs to the finished access.
            ready      = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      sram_we_n  = ~(in_phase & is_wr);
      sram_oe_n  = ~(in_phase & ~is_wr);
      sram_dq_oe = in_phase & is_wr;
   end

   // NOTE: these are control/data registers, not a memory array, so all of
   // them take the asynchronous reset to give defined outputs straight away.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         is_wr       <= 1'b0;
         word        <= '0;
         wdata_hi    <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
      end else if (start) begin
         is_wr     <= wr_en;
         word      <= address[18:2];
         wdata_hi  <= write_data[31:16];
         sram_addr <= {address[18:2], 1'b0};
         if (wr_en) sram_dq_out <= write_data[15:0];
      end else if (state == LO && last) begin
         // Address and data change only at a phase boundary so the SRAM sees them stable.
         sram_addr <= {word, 1'b1};
         if (is_wr) sram_dq_out <= wdata_hi;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         read_data <= '0;
      end else if (last && !is_wr) begin
         if (state == LO) read_data[15:0]  <= sram_dq_in;
         if (state == HI) read_data[31:16] <= sram_dq_in;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, reset/W=0 sequences,
// and random loads/stores checked against a word-level memory model.
module tb_mem_access_ctrl;

   localparam int W1 = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        wr_en = 1'b0, rd_en = 1'b0;
   logic [31:0] address = '0, write_data = '0;
   logic [31:0] read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
   logic        sram_dq_oe, sram_we_n, sram_oe_n;

   logic        z_wr_en = 1'b0, z_rd_en = 1'b0;
   logic [31:0] z_address = '0, z_write_data = '0;
   logic [31:0] z_read_data;
   logic        z_ready;
   logic [17:0] z_sram_addr;
   logic [15:0] z_dq_out, z_dq_in;
   logic        z_dq_oe, z_we_n, z_oe_n;

   int pass_cnt = 0;
   int total_cnt = 0;

   bit [15:0] sram_mem   [0:262143];
   bit [15:0] z_sram_mem [0:262143];
   bit [31:0] ref_mem [bit [16:0]];
   logic [31:0] last_rdata = '0;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        idle_after;
   } vec_t;
   vec_t vecs [7];

   always #5 clk = ~clk;

   mem_access_ctrl #(.WAIT_CYCLES(W1)) u_dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
   );

   mem_access_ctrl #(.WAIT_CYCLES(0)) u_dut_w0 (
      .clk(clk), .rst(rst), .wr_en(z_wr_en), .rd_en(z_rd_en), .address(z_address),
      .write_data(z_write_data), .read_data(z_read_data), .ready(z_ready),
      .sram_addr(z_sram_addr), .sram_dq_out(z_dq_out), .sram_dq_oe(z_dq_oe),
      .sram_dq_in(z_dq_in), .sram_we_n(z_we_n), .sram_oe_n(z_oe_n)
   );

   // Asynchronous SRAM models: combinational read, write while we_n is low.
   assign sram_dq_in = sram_mem[sram_addr];
   assign z_dq_in    = z_sram_mem[z_sram_addr];
   always @(posedge clk) begin
      if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;
      if (!z_we_n)    z_sram_mem[z_sram_addr] <= z_dq_out;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_read(input logic [16:0] w);
      return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
   endfunction

   task automatic idle_cycle();
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
      #1;
      check("idle_ready", ready, 1);
      check("idle_strobes", {sram_we_n, sram_oe_n, sram_dq_oe}, 3'b110);
      check("idle_rdata_hold", read_data, last_rdata);
   endtask

   // One full access starting next cycle; the request is held through DONE like a frozen pipeline.
   task automatic run_access(input logic wr, input logic rd, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] exp_rd);
      int          lat = 2 * (W1 + 1) + 1;
      logic [16:0] w   = addr[18:2];
      logic        hi;
      tick();
      wr_en      = wr;
      rd_en      = rd;
      address    = addr;
      write_data = wd;
      #1;
      check("ready_req", ready, 0);
      for (int c = 1; c <= lat; c++) begin
         tick();
         #1;
         if (c < lat) begin
            hi = (c > W1 + 1);
            check("ready_busy", ready, 0);
            check("sram_addr", sram_addr, {w, hi});
            if (wr) begin
               check("wr_strobes", {sram_we_n, sram_oe_n, sram_dq_oe}, 3'b011);
               check("dq_out", sram_dq_out, hi ? wd[31:16] : wd[15:0]);
            end else begin
               check("rd_strobes", {sram_we_n, sram_oe_n, sram_dq_oe}, 3'b100);
            end
         end else begin
            check("ready_done", ready, 1);
            check("done_strobes", {sram_we_n, sram_oe_n, sram_dq_oe}, 3'b110);
            if (!wr) last_rdata = exp_rd;
            check("read_data", read_data, last_rdata);
         end
      end
      if (wr) ref_mem[w] = wd;
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 1'b1};
      vecs[2] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0, 1'b1};
      vecs[3] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0,        32'h1234_5678, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 32'hFFF7_FFFC, 32'hA5A5_5A5A, 32'h0, 1'b1};
      vecs[5] = '{1'b0, 1'b1, 32'h0007_FFFC, 32'h0,        32'hA5A5_5A5A, 1'b0};
      vecs[6] = '{1'b0, 1'b1, 32'h0000_0013, 32'h0,        32'hDEAD_BEEF, 1'b1};

      // Reset with a pending store: strobes idle, ready follows the request.
      wr_en = 1'b1;
      #1;
      check("rst_strobes", {sram_we_n, sram_oe_n, sram_dq_oe}, 3'b110);
      check("rst_rdata", read_data, 0);
      check("rst_addr", sram_addr, 0);
      check("rst_ready_req", ready, 0);
      wr_en = 1'b0;
      #1;
      check("rst_ready_idle", ready, 1);
      tick();
      rst = 1'b1;

      foreach (vecs[i]) begin
         run_access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);
         if (vecs[i].idle_after) idle_cycle();
      end

      // Reset pulsed during the high half of a store.
      tick();
      wr_en      = 1'b1;
      address    = 32'h0000_0400;
      write_data = 32'h1111_2222;
      repeat (3) tick();
      check("pre_rst_hi_addr", sram_addr, 18'h201);
      check("pre_rst_we", sram_we_n, 0);
      rst = 1'b0;
      #1;
      check("rst_mid_strobes", {sram_we_n, sram_oe_n, sram_dq_oe}, 3'b110);
      check("rst_mid_addr", sram_addr, 0);
      check("rst_mid_dq", sram_dq_out, 0);
      check("rst_mid_rdata", read_data, 0);
      check("rst_mid_ready", ready, 0);
      last_rdata = '0;
      wr_en = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check("post_rst_ready", ready, 1);
      run_access(1'b0, 1'b1, 32'h0000_0010, 32'h0, ref_read(17'h4));
      idle_cycle();

      // Random loads/stores against the word-level model.
      for (int n = 0; n < 40; n++) begin
         int          op = $urandom_range(0, 2);
         logic [16:0] w  = 17'($urandom_range(0, 7));
         logic [31:0] a  = ($urandom & 32'hFFF8_0003) | (32'(w) << 2);
         logic [31:0] d  = $urandom;
         run_access(op != 1, op != 0, a, d, ref_read(w));
         if ($urandom_range(0, 1) == 1) idle_cycle();
      end
      idle_cycle();

      // WAIT_CYCLES = 0: one cycle per half.
      tick();
      z_wr_en = 1'b1;
      z_address = 32'h0000_0004;
      z_write_data = 32'hCAFE_F00D;
      #1;
      check("w0_ready_c0", z_ready, 0);
      tick();
      check("w0_c1", {z_ready, z_we_n, z_sram_addr, z_dq_out}, {2'b00, 18'h2, 16'hF00D});
      tick();
      check("w0_c2", {z_ready, z_we_n, z_sram_addr, z_dq_out}, {2'b00, 18'h3, 16'hCAFE});
      tick();
      check("w0_c3", {z_ready, z_we_n, z_dq_oe}, 3'b110);
      tick();
      z_wr_en = 1'b0;
      z_rd_en = 1'b1;
      #1;
      check("w0_rd_c0", z_ready, 0);
      tick();
      check("w0_rd_c1", {z_ready, z_oe_n, z_sram_addr}, {2'b00, 18'h2});
      tick();
      check("w0_rd_c2", {z_ready, z_oe_n, z_sram_addr}, {2'b00, 18'h3});
      tick();
      check("w0_rd_ready", z_ready, 1);
      check("w0_rd_data", z_read_data, 32'hCAFE_F00D);
      tick();
      z_rd_en = 1'b0;
      #1;
      check("w0_idle", z_ready, 1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencing controller for the MEM pipeline stage's data-memory access. It accepts one 32-bit load or store per instruction and splits it into two 16-bit half-word accesses to an external asynchronous SRAM, adding a configurable number of wait cycles to each half. It drives `ready`, which the pipeline inverts to generate `freeze` for the stage registers while an access is in flight.

## Interface
- `WAIT_CYCLES`, default 1: extra cycles per half-word phase, legal range 0..7.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `wr_en`, in, 1: store request from the MEM stage.
- `rd_en`, in, 1: load request from the MEM stage.
- `address`, in, 32: byte address. Only `address[18:2]` is used.
- `write_data`, in, 32: store data.
- `read_data`, out, 32: load result, registered.
- `ready`, out, 1: high when no access is pending or one is completing. The pipeline uses `freeze = ~ready`.
- `sram_addr`, out, 18: half-word address, `{address[18:2], half}`.
- `sram_dq_out`, out, 16: data driven to the SRAM.
- `sram_dq_oe`, out, 1: tristate enable for `sram_dq_out`.
- `sram_dq_in`, in, 16: data read from the SRAM.
- `sram_we_n`, out, 1: SRAM write strobe, active-low.
- `sram_oe_n`, out, 1: SRAM output enable, active-low.

## Operation
- FSM states are IDLE, LO, HI and DONE. A phase counter `cnt` counts 0..`WAIT_CYCLES`.
- **IDLE**
  - `ready = ~(rd_en | wr_en)`; this path is combinational.
  - On a request, capture the op, `address[18:2]` and `write_data`, clear `cnt`, and go to LO.
  - If `rd_en` and `wr_en` are both high, the write wins.
- **LO**
  - `sram_addr = {word, 1'b0}`.
  - Write: `sram_dq_out = wdata[15:0]`, `sram_dq_oe = 1`, `sram_we_n = 0`.
  - Read: `sram_oe_n = 0`, and `sram_dq_in` is captured into `read_data[15:0]` on the cycle where `cnt == WAIT_CYCLES`.
  - When `cnt == WAIT_CYCLES`: clear `cnt` and go to HI. Otherwise increment `cnt`.
- **HI**
  - Same as LO, using `{word, 1'b1}` and `wdata[31:16]`.
  - Read data is captured into `read_data[31:16]`.
  - On the last cycle, go to DONE.
- **DONE**
  - `ready = 1` and all SRAM strobes are inactive.
  - Always returns to IDLE.
  - The request inputs are ignored in DONE. The instruction that is still present in DONE is never restarted; the next instruction's request is seen in the following IDLE cycle.
- `read_data` holds its value until the next read's capture. A write never modifies it.
- Outside LO/HI: `sram_we_n = 1`, `sram_oe_n = 1`, `sram_dq_oe = 0`, and `sram_addr` holds its last value.

## Timing
- Reset values:
  - state IDLE, `cnt` 0, `read_data` 0, `sram_addr` 0, `sram_dq_out` 0;
  - `sram_dq_oe` 0, `sram_we_n` 1, `sram_oe_n` 1;
  - `ready` equals `~(rd_en|wr_en)`.
- Latency: the request is sampled in IDLE at cycle 0, and `ready` goes high at cycle 2·(`WAIT_CYCLES`+1)+1.
  - `WAIT_CYCLES` = 1: `ready` is low in cycles 0–4 and high in cycle 5.
  - `WAIT_CYCLES` = 0: `ready` is high in cycle 3.
- Each phase lasts exactly `WAIT_CYCLES`+1 cycles. The SRAM address and data are stable for the whole phase.
- Read data is valid on `read_data` in the DONE cycle.
- Throughput: the next access can start in the cycle after DONE. That gives 2·(W+1)+2 cycles per access back-to-back.
- Reset asserted mid-access:
  - all outputs return to their reset values immediately;
  - the access is abandoned, and a partial write (LO half only) is permitted;
  - after reset, the controller starts in IDLE.

## Test plan
- **Reset:** hold `rst`=0 with `wr_en`=1 → `sram_we_n`=1, `sram_oe_n`=1, `sram_dq_oe`=0, `read_data`=0, `ready`=0. With `wr_en`=`rd_en`=0 → `ready`=1.
- **Store, W=1:** `wr_en`, `address`=0x0000_0010, `write_data`=0xDEADBEEF →
  - cycles 1–2: `sram_addr`=0x00008, `dq_out`=0xBEEF, `we_n`=0;
  - cycles 3–4: `sram_addr`=0x00009, `dq_out`=0xDEAD;
  - `ready`=1 only in cycle 5.
- **Load, W=1:** SRAM model holds 0xBEEF at 0x8 and 0xDEAD at 0x9; `rd_en` at 0x10 → `oe_n`=0 in cycles 1–4, `read_data`=0xDEADBEEF in cycle 5 and held afterwards.
- **Back-to-back:** request held through DONE, then a new load is presented → exactly one access per instruction, with the second access starting the cycle after DONE.
- **Conflict and reset:** `rd_en`=`wr_en`=1 → a write is performed. Reset pulsed during HI → strobes go inactive in the same cycle, and the state is IDLE after release.
- **W=0:** store at 0x4 → one cycle per half, `ready`=1 in cycle 3.
